// File: rtl/udma_hyper_fifo_pkg.sv
// Shared sizing helpers for the uDMA HyperBus RX packer FIFO.
// Stored entries use the packed layout {data, strb, last}.
package udma_hyper_fifo_pkg;

    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int lane_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int entry_width(input int in_w, input int ratio);
        return in_w * ratio + ratio + 1;
    endfunction

endpackage

// File: rtl/udma_hyper_lane_packer.sv
// Gathers RATIO narrow input words into one wide word with lane strobes.
// Emits a commit when the last lane fills or the burst ends early.
module udma_hyper_lane_packer
    import udma_hyper_fifo_pkg::*;
#(
    parameter  int IN_WIDTH  = 16,
    parameter  int RATIO     = 2,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 accept_i,
    input  logic [IN_WIDTH-1:0]  data_i,
    input  logic                 last_i,
    output logic                 commit_o,
    output logic [OUT_WIDTH-1:0] word_o,
    output logic [RATIO-1:0]     strb_o,
    output logic                 last_o
);

    localparam int LANE_W = lane_width(RATIO);
    localparam int PACK_W = (RATIO > 1) ? (RATIO - 1) * IN_WIDTH : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0] lane_q;
    logic [PACK_W-1:0] pack_q;
    logic [RATIO-1:0]  strb_q;
    logic              at_last;

    assign at_last  = (lane_q == LAST_LANE);
    assign commit_o = accept_i && (at_last || last_i);
    assign last_o   = last_i;

    // Lanes above lane_q are still zero in pack_q, so an early
    // commit leaves them cleared with their strobes off.
    always_comb begin
        word_o = '0;
        word_o[PACK_W-1:0] = pack_q;
        word_o[lane_q*IN_WIDTH +: IN_WIDTH] = data_i;
        strb_o = strb_q;
        strb_o[lane_q] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            lane_q <= '0;
            pack_q <= '0;
            strb_q <= '0;
        end else if (commit_o) begin
            lane_q <= '0;
            pack_q <= '0;
            strb_q <= '0;
        end else if (accept_i) begin
            lane_q <= lane_q + LANE_W'(1);
            pack_q <= word_o[PACK_W-1:0];
            strb_q <= strb_o;
        end
    end

endmodule

// File: rtl/udma_hyper_rx_packer_fifo.sv
// System-side RX buffer for the uDMA HyperBus channel: lane packer
// in front of a first-word-fall-through circular buffer.
module udma_hyper_rx_packer_fifo
    import udma_hyper_fifo_pkg::*;
#(
    parameter  int IN_WIDTH  = 16,
    parameter  int RATIO     = 2,
    parameter  int DEPTH     = 8,
    parameter  int AF_THRESH = DEPTH - 2,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int LVL_W     = lvl_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic                 in_valid_i,
    input  logic                 in_last_i,
    output logic                 in_ready_o,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic [RATIO-1:0]     out_strb_o,
    output logic                 out_last_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [LVL_W-1:0]     level_o,
    output logic                 almost_full_o,
    output logic                 empty_o
);

    localparam int PTR_W = ptr_width(DEPTH);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [RATIO-1:0]     strb;
        logic                 last;
    } entry_t;

    entry_t               mem [DEPTH];
    entry_t               head;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic                 accept;
    logic                 commit;
    logic                 pop;
    logic [OUT_WIDTH-1:0] commit_data;
    logic [RATIO-1:0]     commit_strb;
    logic                 commit_last;

    // Ready looks only at the registered level, never at out_ready_i.
    assign in_ready_o = (level_q < LVL_W'(DEPTH)) && !flush_i && !rst_i;
    assign accept     = in_valid_i && in_ready_o;
    assign pop        = out_valid_o && out_ready_i && !flush_i;

    udma_hyper_lane_packer #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO)
    ) u_packer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .flush_i  (flush_i),
        .accept_i (accept),
        .data_i   (in_data_i),
        .last_i   (in_last_i),
        .commit_o (commit),
        .word_o   (commit_data),
        .strb_o   (commit_strb),
        .last_o   (commit_last)
    );

    always_ff @(posedge clk_i) begin
        if (commit) begin
            mem[wr_ptr_q] <= '{data: commit_data,
                               strb: commit_strb,
                               last: commit_last};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (commit) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({commit, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign head          = mem[rd_ptr_q];
    assign out_valid_o   = (level_q != '0);
    assign out_data_o    = head.data;
    assign out_strb_o    = out_valid_o ? head.strb : '0;
    assign out_last_o    = out_valid_o && head.last;
    assign level_o       = level_q;
    assign almost_full_o = (level_q >= LVL_W'(AF_THRESH));
    assign empty_o       = (level_q == '0);

endmodule
